// File: rtl/fft_capture_pkg.sv
// -----------------------------------------------------------------------------
// fft_capture_pkg
// Shared definitions for the FFT frame-capture slice:
//   FFT_LGSIZE  log2 of the FFT size (frame = 2**FFT_LGSIZE bins)
//   FFT_OWIDTH  bits per real/imag component of the FFT output stream
//   FFT_MWIDTH  magnitude-squared width (unsigned, 2*FFT_OWIDTH)
//   ST_*        capture-state encoding {IDLE, CAPTURE, DRAIN, HOLD}
//   sat_inc8    saturating 8-bit increment used by the drop counter
// -----------------------------------------------------------------------------
package fft_capture_pkg;

  localparam int FFT_LGSIZE = 7;
  localparam int FFT_OWIDTH = 12;
  localparam int FFT_MWIDTH = 2 * FFT_OWIDTH;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/fft_magsq.sv
// -----------------------------------------------------------------------------
// fft_magsq
// Magnitude-squared pipeline for one complex FFT bin: re*re + im*im.
// Stage 1 (this module) registers both signed products together with a valid
// bit and the bin index. Stage 2 is the sum presented on o_mag, which the
// parent registers on the next clock (buffer write), so the result lands two
// clocks after the sample is accepted. The pipeline advances every clock.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset (clears valid only)
//   i_valid         sample accepted this clock
//   i_idx           bin index of the sample
//   i_sample        {re, im}, signed, real in the upper half
//   o_valid         stage-2 data valid
//   o_idx           bin index travelling with o_mag
//   o_mag           |X|^2, unsigned MWIDTH bits
// -----------------------------------------------------------------------------
module fft_magsq #(
  parameter int IWIDTH = 12,
  parameter int LGSIZE = 7,
  parameter int MWIDTH = 2 * IWIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [LGSIZE-1:0]     i_idx,
  input  logic [2*IWIDTH-1:0]   i_sample,
  output logic                  o_valid,
  output logic [LGSIZE-1:0]     o_idx,
  output logic [MWIDTH-1:0]     o_mag
);

  logic signed [IWIDTH-1:0] re;
  logic signed [IWIDTH-1:0] im;
  logic signed [MWIDTH-1:0] re_x;
  logic signed [MWIDTH-1:0] im_x;

  assign re   = i_sample[2*IWIDTH-1:IWIDTH];
  assign im   = i_sample[IWIDTH-1:0];
  // Sign-extend before multiplying so the product is formed at full width.
  assign re_x = MWIDTH'(re);
  assign im_x = MWIDTH'(im);

  logic                 s1_valid;
  logic [LGSIZE-1:0]    s1_idx;
  logic [MWIDTH-1:0]    s1_re_sq;
  logic [MWIDTH-1:0]    s1_im_sq;

  // NOTE: only the valid bit is reset; index and products are qualified by it,
  // so leaving them unreset keeps the datapath free of reset fan-out.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= i_valid;
    end
    s1_idx   <= i_idx;
    s1_re_sq <= $unsigned(re_x * re_x);
    s1_im_sq <= $unsigned(im_x * im_x);
  end

  // Squares are non-negative and their sum peaks at 2*(2^(IWIDTH-1))^2,
  // which fits MWIDTH without carry out.
  assign o_valid = s1_valid;
  assign o_idx   = s1_idx;
  assign o_mag   = s1_re_sq + s1_im_sq;

endmodule

// File: rtl/fft_frame_capture.sv
// -----------------------------------------------------------------------------
// fft_frame_capture
// Consumer at the output of a pipelined FFT stream. Aligns on i_sync, turns
// each bin into |X|^2, captures one full frame into a RAM and holds it for
// host read-out until i_frame_ack. Frames that arrive while a frame is held
// are counted (saturating) and dropped.
// Optional feature macro: FFT_CAPTURE_PEAK_EN -- track the peak bin of each
// captured frame (lowest bin wins ties); when undefined the peak outputs are 0.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_ce            sample strobe qualifying i_result / i_sync
//   i_sync          marks bin 0 of each frame
//   i_result        {re, im}, signed, real in the upper half
//   o_frame_valid   a complete frame is held in the buffer
//   i_frame_ack     host releases the held frame (honoured only in HOLD)
//   i_rd_addr       host read bin index
//   o_rd_data       |X[i_rd_addr]|^2, one clock read latency
//   o_drop_count    frames dropped while holding, saturates at 255
//   o_err_resync    sticky: i_sync seen mid-capture
//   o_peak_bin      bin of the largest magnitude in the held frame
//   o_peak_mag      magnitude of that bin
// -----------------------------------------------------------------------------
module fft_frame_capture
  import fft_capture_pkg::*;
#(
  parameter int IWIDTH = FFT_OWIDTH,
  parameter int LGSIZE = FFT_LGSIZE,
  parameter int MWIDTH = 2 * IWIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic                 i_sync,
  input  logic [2*IWIDTH-1:0]  i_result,
  output logic                 o_frame_valid,
  input  logic                 i_frame_ack,
  input  logic [LGSIZE-1:0]    i_rd_addr,
  output logic [MWIDTH-1:0]    o_rd_data,
  output logic [7:0]           o_drop_count,
  output logic                 o_err_resync,
  output logic [LGSIZE-1:0]    o_peak_bin,
  output logic [MWIDTH-1:0]    o_peak_mag
);

  logic [1:0]         state;
  logic [LGSIZE-1:0]  bin_cnt;     // index the next accepted sample will take
  logic               drain_cnt;
  logic               sync_strobe;
  logic               accept;
  logic [LGSIZE-1:0]  accept_idx;

  assign sync_strobe = i_ce && i_sync;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    accept     = 1'b0;
    accept_idx = bin_cnt;
    case (state)
      ST_IDLE:    accept = sync_strobe;
      ST_CAPTURE: accept = i_ce;
      default:    accept = 1'b0;
    endcase
    // A sync always starts a frame, including a resync mid-capture.
    if (sync_strobe) begin
      accept_idx = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      bin_cnt      <= '0;
      drain_cnt    <= 1'b0;
      o_drop_count <= 8'd0;
      o_err_resync <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sync_strobe) begin
            state   <= ST_CAPTURE;
            bin_cnt <= LGSIZE'(1);
          end
        end
        ST_CAPTURE: begin
          if (i_ce) begin
            if (i_sync) begin
              // bin_cnt is never 0 in CAPTURE, so any sync here is early.
              o_err_resync <= 1'b1;
              bin_cnt      <= LGSIZE'(1);
            end else if (&bin_cnt) begin
              state     <= ST_DRAIN;
              drain_cnt <= 1'b0;
            end else begin
              bin_cnt <= bin_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Two clocks: the last product retires, then the last RAM write.
          if (drain_cnt) begin
            state <= ST_HOLD;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (sync_strobe) begin
            o_drop_count <= sat_inc8(o_drop_count);
          end
          if (i_frame_ack) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_frame_valid = (state == ST_HOLD);

  logic               mag_valid;
  logic [LGSIZE-1:0]  mag_idx;
  logic [MWIDTH-1:0]  mag;

  fft_magsq #(
    .IWIDTH (IWIDTH),
    .LGSIZE (LGSIZE),
    .MWIDTH (MWIDTH)
  ) u_magsq (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (accept),
    .i_idx    (accept_idx),
    .i_sample (i_result),
    .o_valid  (mag_valid),
    .o_idx    (mag_idx),
    .o_mag    (mag)
  );

  // NOTE: the frame buffer has no reset so it maps onto a block RAM; stale
  // contents are harmless because o_frame_valid gates their use.
  logic [MWIDTH-1:0] frame_buf [2**LGSIZE];

  always_ff @(posedge i_clk) begin
    if (mag_valid) begin
      frame_buf[mag_idx] <= mag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rd_data <= '0;
    end else begin
      o_rd_data <= frame_buf[i_rd_addr];
    end
  end

`ifdef FFT_CAPTURE_PEAK_EN
  logic [MWIDTH-1:0] run_peak_mag;
  logic [LGSIZE-1:0] run_peak_bin;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      run_peak_mag <= '0;
      run_peak_bin <= '0;
      o_peak_mag   <= '0;
      o_peak_bin   <= '0;
    end else begin
      if (mag_valid) begin
        // Bin 0 restarts the search; strict '>' keeps the lowest bin on ties.
        if (mag_idx == '0) begin
          run_peak_mag <= mag;
          run_peak_bin <= '0;
        end else if (mag > run_peak_mag) begin
          run_peak_mag <= mag;
          run_peak_bin <= mag_idx;
        end
      end
      // Publish on the DRAIN->HOLD edge; the last bin is already folded in.
      if (state == ST_DRAIN && drain_cnt) begin
        o_peak_mag <= run_peak_mag;
        o_peak_bin <= run_peak_bin;
      end
    end
  end
`else
  assign o_peak_bin = '0;
  assign o_peak_mag = '0;
`endif

endmodule

// File: tb/tb_fft_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_capture
// Drives randomized FFT frames into fft_frame_capture. A frame-level reference
// model (queues of magnitudes, built from the capture rules) predicts the held
// frame; read-outs push expected words into a scoreboard queue that a separate
// monitor pops whenever read data is due.
// -----------------------------------------------------------------------------
module tb_fft_frame_capture;

  localparam int IW = 12;
  localparam int LG = 7;
  localparam int MW = 24;
  localparam int N  = 128;

  logic           i_clk = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_ce = 1'b0;
  logic           i_sync = 1'b0;
  logic [2*IW-1:0] i_result = '0;
  logic           i_frame_ack = 1'b0;
  logic [LG-1:0]  i_rd_addr = '0;
  logic           o_frame_valid;
  logic [MW-1:0]  o_rd_data;
  logic [7:0]     o_drop_count;
  logic           o_err_resync;
  logic [LG-1:0]  o_peak_bin;
  logic [MW-1:0]  o_peak_mag;

  fft_frame_capture dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_ce          (i_ce),
    .i_sync        (i_sync),
    .i_result      (i_result),
    .o_frame_valid (o_frame_valid),
    .i_frame_ack   (i_frame_ack),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_drop_count  (o_drop_count),
    .o_err_resync  (o_err_resync),
    .o_peak_bin    (o_peak_bin),
    .o_peak_mag    (o_peak_mag)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_bins[$];
  int m_frame[N];
  bit m_busy = 0;
  bit m_held = 0;
  int m_drop = 0;
  bit m_err  = 0;

  function automatic void model_sample(input int mag, input bit sync);
    if (m_held) begin
      if (sync && m_drop < 255) m_drop++;
    end else if (!m_busy) begin
      if (sync) begin
        m_busy = 1;
        m_bins.delete();
        m_bins.push_back(mag);
      end
    end else begin
      if (sync) begin
        m_err = 1;
        m_bins.delete();
      end
      m_bins.push_back(mag);
      if (m_bins.size() == N) begin
        for (int i = 0; i < N; i++) m_frame[i] = m_bins[i];
        m_busy = 0;
        m_held = 1;
      end
    end
  endfunction

  function automatic void model_reset();
    m_busy = 0;
    m_held = 0;
    m_drop = 0;
    m_err  = 0;
    m_bins.delete();
  endfunction

  function automatic int rnd_comp(input int span);
    return int'($urandom_range(2 * span - 1)) - span;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int addr;
    int mag;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  logic    rd_issue = 1'b0;
  logic    rd_due = 1'b0;

  always @(posedge i_clk) rd_due <= rd_issue;

  always @(negedge i_clk) begin : monitor
    rd_exp_t e;
    if (rd_due) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("rd_data[%0d]", e.addr), o_rd_data, e.mag);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int re, input int im, input bit sync);
    logic [IW-1:0] r12;
    logic [IW-1:0] m12;
    r12 = IW'(re);
    m12 = IW'(im);
    i_result = {r12, m12};
    i_ce     = 1'b1;
    i_sync   = sync;
    model_sample(re * re + im * im, sync);
    step();
    i_ce   = 1'b0;
    i_sync = 1'b0;
  endtask

  task automatic ack(input bit with_sync);
    i_frame_ack = 1'b1;
    i_ce        = with_sync;
    i_sync      = with_sync;
    if (m_held) begin
      if (with_sync && m_drop < 255) m_drop++;
      m_held = 0;
    end else if (with_sync) begin
      model_sample(0, 1'b1);
    end
    step();
    i_frame_ack = 1'b0;
    i_ce        = 1'b0;
    i_sync      = 1'b0;
  endtask

  task automatic random_frame(input int gap);
    for (int k = 0; k < N; k++) begin
      send(rnd_comp(2048), rnd_comp(2048), k == 0);
      idle(gap);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!o_frame_valid && n < 20) begin
      step();
      n++;
    end
    check(name, o_frame_valid, 1);
  endtask

  task automatic read_frame();
    for (int a = 0; a < N; a++) begin
      i_rd_addr = LG'(a);
      rd_issue  = 1'b1;
      sb_q.push_back('{a, m_frame[a]});
      step();
    end
    rd_issue = 1'b0;
    idle(2);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_frame_valid"}, o_frame_valid, m_held);
    check({tag, "_drop_count"}, o_drop_count, m_drop);
    check({tag, "_err_resync"}, o_err_resync, m_err);
  endtask

  task automatic check_peak(input string tag);
    int pb = 0;
    int pm = 0;
`ifdef FFT_CAPTURE_PEAK_EN
    pm = m_frame[0];
    for (int i = 1; i < N; i++) begin
      if (m_frame[i] > pm) begin
        pm = m_frame[i];
        pb = i;
      end
    end
`endif
    check({tag, "_peak_bin"}, o_peak_bin, pb);
    check({tag, "_peak_mag"}, o_peak_mag, pm);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    idle(3);
    i_reset = 1'b0;
    // Reset state.
    check("rst_frame_valid", o_frame_valid, 0);
    check("rst_drop_count", o_drop_count, 0);
    check("rst_err_resync", o_err_resync, 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_peak_bin", o_peak_bin, 0);
    check("rst_peak_mag", o_peak_mag, 0);

    // Ramp frame, dense: bin k = {k, 0}; valid 3 clocks after the last sample.
    for (int k = 0; k < N; k++) send(k, 0, k == 0);
    check("ramp_valid_c1", o_frame_valid, 0);
    step();
    check("ramp_valid_c2", o_frame_valid, 0);
    step();
    check("ramp_valid_c3", o_frame_valid, 1);
    i_rd_addr = LG'(5);
    step();
    check("ramp_addr5", o_rd_data, 25);
    read_frame();
    check_status("ramp");
    check_peak("ramp");

    // Ack drops o_frame_valid on the next cycle.
    ack(1'b0);
    check("ack_clears_valid", o_frame_valid, 0);

    // Most negative bin 0, zeros elsewhere.
    send(-2048, -2048, 1'b1);
    for (int k = 1; k < N; k++) send(0, 0, 1'b0);
    wait_valid("neg_valid");
    read_frame();
    check_peak("neg");
    ack(1'b0);

    // Sparse strobe: i_ce every third clock.
    random_frame(2);
    wait_valid("gap_valid");
    read_frame();
    check_peak("gap");

    // Three synced frames while holding, held frame must survive.
    for (int f = 0; f < 3; f++) begin
      send(rnd_comp(2048), rnd_comp(2048), 1'b1);
      for (int k = 0; k < 5; k++) send(rnd_comp(2048), rnd_comp(2048), 1'b0);
      idle(1);
    end
    check("hold_drop3", o_drop_count, 3);
    read_frame();
    // Ack together with a 4th sync: counted as dropped, block returns to IDLE.
    ack(1'b1);
    check("ack_sync_drop4", o_drop_count, 4);
    check("ack_sync_idle", o_frame_valid, 0);
    idle(3);
    random_frame(0);
    wait_valid("after_drop_valid");
    read_frame();
    check_status("after_drop");
    check_peak("after_drop");
    ack(1'b0);

    // Resync at bin 40; the frame restarts from the new sync.
    for (int k = 0; k < 40; k++) send(rnd_comp(2048), rnd_comp(2048), k == 0);
    send(rnd_comp(2048), rnd_comp(2048), 1'b1);
    check("resync_err", o_err_resync, 1);
    for (int k = 1; k < N; k++) send(rnd_comp(2048), rnd_comp(2048), 1'b0);
    wait_valid("resync_valid");
    check_status("resync");
    read_frame();
    check_peak("resync");
    ack(1'b0);

    // Ack outside HOLD is ignored; then tied maxima at bins 10 and 90.
    ack(1'b0);
    check("stray_ack_idle", o_frame_valid, 0);
    for (int k = 0; k < N; k++) begin
      if (k == 10 || k == 90) send(-2048, -2048, 1'b0);
      else send(rnd_comp(1000), rnd_comp(1000), k == 0);
    end
    wait_valid("tie_valid");
    read_frame();
    check_peak("tie");
    ack(1'b0);

    // Reset mid-capture: no frame may be flagged until a full new one.
    for (int k = 0; k < 50; k++) send(rnd_comp(2048), rnd_comp(2048), k == 0);
    i_reset = 1'b1;
    idle(2);
    i_reset = 1'b0;
    model_reset();
    check_status("midrst");
    for (int k = 0; k < 60; k++) send(rnd_comp(2048), rnd_comp(2048), 1'b0);
    idle(5);
    check("midrst_nosync_valid", o_frame_valid, 0);
    random_frame(0);
    wait_valid("midrst_valid");
    read_frame();
    check_status("midrst_final");
    check_peak("midrst");

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
